fun_sched: RTL and testbench

Job scheduler that sits directly upstream of the `fun` core (result = a · ∛b, 8-bit operands, 11-bit result, start/busy handshake).
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Issues each pair to `fun` with a one-cycle `start` pulse, waits for `busy` to drop, and returns results in order on a valid/ready output stream.
- A watchdog recovers the core if `busy` never falls.

---
 rtl/fun_sched.sv | 134 +++++++++++++
 tb/tb_fun_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fun_sched.sv
// fun_sched: job scheduler in front of the fun core (result = a * cbrt(b)).
// Buffers operand pairs in a small FIFO, issues them to the core one at a
// time with a start pulse, returns results in order on a valid/ready stream,
// and recovers the core through a watchdog if busy never falls.
module fun_sched #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_a,
  input  logic [7:0]                    in_b,
  output logic [7:0]                    fun_a_o,
  output logic [7:0]                    fun_b_o,
  output logic                          fun_start,
  output logic                          fun_rst_o,
  input  logic                          fun_busy,
  input  logic [10:0]                   fun_result,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [10:0]                   out_result,
  output logic                          out_timeout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  FULL    = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]     state;
  logic [WDW-1:0] wd_cnt;
  logic [15:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           push;
  logic           pop;

  assign in_ready  = !rst && (fifo_count != FULL);
  assign push      = in_valid && in_ready;
  assign pop       = (state == S_IDLE) && (fifo_count != '0);
  assign fun_start = (state == S_ISSUE);
  // NOTE: combinational on rst so the core is held in reset in the very
  // cycle reset is asserted, not one edge later.
  assign fun_rst_o = rst | (state == S_RECOVER);

  // Operand storage: written on push, read by the controller on pop.
  // NOTE: the array has no reset; occupancy is tracked by the pointers and
  // count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b};
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Job controller: issue, settle, wait with watchdog, recover, hand off.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      fun_a_o     <= '0;
      fun_b_o     <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_timeout <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            {fun_a_o, fun_b_o} <= mem[rd_ptr];
            state              <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_SETTLE;
        S_SETTLE: begin
          // The core may raise busy only now, so busy is not trusted yet.
          wd_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (!fun_busy) begin
            out_result  <= fun_result;
            out_timeout <= 1'b0;
            out_valid   <= 1'b1;
            state       <= S_DONE;
          end else if (wd_cnt == WD_LAST) begin
            state <= S_RECOVER;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
        end
        S_RECOVER: begin
          out_result  <= '0;
          out_timeout <= 1'b1;
          out_valid   <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fun_sched.sv
// tb_fun_sched: randomized and directed stimulus for fun_sched, with a
// behavioural fun core and an in-order scoreboard of expected results.
module tb_fun_sched;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic [7:0]  fun_a_o;
  logic [7:0]  fun_b_o;
  logic        fun_start;
  logic        fun_rst_o;
  logic        fun_busy = 1'b0;
  logic [10:0] fun_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [10:0] out_result;
  logic        out_timeout;
  logic [2:0]  fifo_count;

  fun_sched #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .fun_a_o(fun_a_o), .fun_b_o(fun_b_o),
    .fun_start(fun_start), .fun_rst_o(fun_rst_o), .fun_busy(fun_busy),
    .fun_result(fun_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_timeout(out_timeout),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int cbrt(input int b);
    int r = 0;
    for (int i = 0; i <= 6; i++) if (i * i * i <= b) r = i;
    return r;
  endfunction

  // Behavioural core: busy rises at the start edge, falls after core_lat
  // edges unless stuck; a core reset clears busy.
  int   core_lat  = 3;
  bit   lat_rand  = 1'b0;
  bit   stuck     = 1'b0;
  int   remain    = 0;
  always @(posedge clk) begin
    if (fun_rst_o) begin
      fun_busy <= 1'b0;
      remain   <= 0;
    end else if (fun_start) begin
      fun_result <= 11'(int'(fun_a_o) * cbrt(int'(fun_b_o)));
      fun_busy   <= 1'b1;
      remain     <= lat_rand ? int'($urandom_range(1, 6)) : core_lat;
    end else if (fun_busy && !stuck) begin
      if (remain <= 1) fun_busy <= 1'b0;
      else remain <= remain - 1;
    end
  end

  // Random consumer backpressure, changed just after the active edge.
  bit rand_ready = 1'b0;
  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  typedef struct packed {logic to; logic [10:0] res;} exp_t;
  exp_t exp_q[$];

  int starts  = 0;
  int rpulses = 0;
  int maxc    = 0;

  // Monitor and scoreboard, sampled on the inactive edge.
  always @(negedge clk) begin
    exp_t e;
    if (fun_start) starts++;
    if (!rst && fun_rst_o) rpulses++;
    if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
    check("in_ready", 32'(in_ready), 32'(!rst && fifo_count != 3'(DEPTH)));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("out", 32'({out_timeout, out_result}), 32'(e));
      end
    end
  end

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int w = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b;
    while (!in_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("push_wait", 32'(0), 32'(1));
      in_valid = 1'b0;
      return;
    end
    if (stuck) exp_q.push_back('{to: 1'b1, res: 11'd0});
    else       exp_q.push_back('{to: 1'b0, res: 11'(int'(a) * cbrt(int'(b)))});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not terminate");
  end

  initial begin
    int cyc;
    int w;
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_fun_rst", 32'(fun_rst_o), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_count", 32'(fifo_count), 32'(0));
    check("rst_start", 32'(fun_start), 32'(0));
    check("rst_a", 32'({fun_a_o, fun_b_o}), 32'(0));
    check("rst_result", 32'({out_timeout, out_result}), 32'(0));
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'(1));
    check("post_rst_fun_rst", 32'(fun_rst_o), 32'(0));

    // Single job with a fixed core latency of 3 (N = 2 busy samples in WAIT)
    starts = 0;
    core_lat = 3;
    push(8'd5, 8'd27);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
      if (cyc == 5) check("hold_ab", 32'({fun_a_o, fun_b_o}), 32'({8'd5, 8'd27}));
    end
    check("latency", 32'(cyc), 32'(6));
    drain();
    check("single_starts", 32'(starts), 32'(1));

    // Burst, consumer always ready
    lat_rand = 1'b1;
    maxc = 0;
    push(8'd5, 8'd27);   push(8'd3, 8'd64);  push(8'd9, 8'd125);
    push(8'd255, 8'd200); push(8'd3, 8'd64); push(8'd5, 8'd27);
    drain();
    check("burst_full", 32'(maxc), 32'(DEPTH));

    // Backpressure: result held, no new start while stalled
    set_ready(1'b0);
    push(8'd5, 8'd27);
    push(8'd3, 8'd64);
    w = 0;
    while (!out_valid && w < 200) begin @(negedge clk); w++; end
    check("bp_valid", 32'(out_valid), 32'(1));
    starts = 0;
    repeat (20) @(negedge clk);
    check("bp_hold", 32'({out_valid, out_result}), 32'({1'b1, 11'd15}));
    check("bp_starts", 32'(starts), 32'(0));
    set_ready(1'b1);
    drain();

    // Simultaneous push and pop with two entries queued
    set_ready(1'b0);
    push(8'd5, 8'd27); push(8'd3, 8'd64); push(8'd9, 8'd125);
    w = 0;
    while (!(out_valid && fifo_count == 3'd2) && w < 200) begin @(negedge clk); w++; end
    check("pp_pre_count", 32'(fifo_count), 32'(2));
    set_ready(1'b1);
    @(posedge clk);
    @(negedge clk);
    check("pp_ready", 32'(in_ready), 32'(1));
    in_valid = 1'b1; in_a = 8'd255; in_b = 8'd200;
    exp_q.push_back('{to: 1'b0, res: 11'd1275});
    @(negedge clk);
    in_valid = 1'b0;
    check("pp_count", 32'(fifo_count), 32'(2));
    drain();

    // Watchdog: core stuck busy
    rpulses = 0;
    stuck = 1'b1;
    push(8'd9, 8'd125);
    drain();
    check("wd_rst_pulses", 32'(rpulses), 32'(1));
    stuck = 1'b0;
    push(8'd3, 8'd64);
    drain();

    // Reset in the middle of a job with two entries queued
    lat_rand = 1'b0;
    core_lat = 6;
    push(8'd5, 8'd27); push(8'd3, 8'd64); push(8'd9, 8'd125);
    w = 0;
    while (!fun_busy && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    check("mid_count", 32'(fifo_count), 32'(2));
    rst = 1'b1;
    #1;
    check("mid_fun_rst", 32'(fun_rst_o), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("mid_after", 32'({out_valid, fifo_count}), 32'(0));
    starts = 0;
    repeat (10) @(negedge clk);
    check("mid_starts", 32'(starts), 32'(0));
    push(8'd9, 8'd125);
    drain();

    // Randomized jobs with random backpressure and core latency
    lat_rand = 1'b1;
    rand_ready = 1'b1;
    for (int j = 0; j < 40; j++) begin
      push(8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rand_ready = 1'b0;
    set_ready(1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
